// File: rtl/fifo_prog.sv
`default_nettype none
// ============================================================================
// fifo_prog : synchronous FIFO with programmable almost flags, sticky
//             overflow/underflow and optional first-word-fallthrough read.
// Revision  : 1.0
// ============================================================================
module fifo_prog #(
  parameter int WIDTH                  = 8,
  parameter int DEPTH                  = 8,
  parameter int FIRST_WORD_FALLTHROUGH = 0,
  parameter int AFULL_THRESH           = DEPTH - 1,
  parameter int AEMPTY_THRESH          = 1
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   flush,
  input  logic                   wr_en,
  input  logic [WIDTH-1:0]       din,
  output logic                   full,
  output logic                   almost_full,
  input  logic                   rd_en,
  output logic [WIDTH-1:0]       dout,
  output logic                   empty,
  output logic                   almost_empty,
  output logic [$clog2(DEPTH):0] count,
  output logic                   overflow,
  output logic                   underflow,
  input  logic                   err_clr
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  if (WIDTH < 1) begin : g_bad_width
    $error("fifo_prog: WIDTH must be at least 1");
  end
  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("fifo_prog: DEPTH must be a power of two and at least 2");
  end
  if (FIRST_WORD_FALLTHROUGH != 0 && FIRST_WORD_FALLTHROUGH != 1) begin : g_bad_fwft
    $error("fifo_prog: FIRST_WORD_FALLTHROUGH must be 0 or 1");
  end
  if (AFULL_THRESH < 1 || AFULL_THRESH > DEPTH) begin : g_bad_afull
    $error("fifo_prog: AFULL_THRESH must be in 1..DEPTH");
  end
  if (AEMPTY_THRESH < 0 || AEMPTY_THRESH > DEPTH - 1) begin : g_bad_aempty
    $error("fifo_prog: AEMPTY_THRESH must be in 0..DEPTH-1");
  end

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic [CW-1:0]    cnt_nxt;
  logic             full_q;
  logic             empty_q;
  logic             afull_q;
  logic             aempty_q;
  logic             ovf_q;
  logic             udf_q;
  logic             wr_acc;
  logic             rd_acc;

  // Accept decisions look only at the registered flags, so a write into a
  // full FIFO is dropped even if a read frees a slot in the same cycle.
  assign wr_acc = wr_en & ~full_q;
  assign rd_acc = rd_en & ~empty_q;

  always_comb begin
    cnt_nxt = cnt;
    if (flush) begin
      cnt_nxt = '0;
    end else if (wr_acc && !rd_acc) begin
      cnt_nxt = cnt + CW'(1);
    end else if (rd_acc && !wr_acc) begin
      cnt_nxt = cnt - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wr_ptr   <= '0;
      rd_ptr   <= '0;
      cnt      <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      afull_q  <= 1'b0;
      aempty_q <= 1'b1;
    end else begin
      if (flush) begin
        wr_ptr <= '0;
        rd_ptr <= '0;
      end else begin
        if (wr_acc) wr_ptr <= wr_ptr + AW'(1);
        if (rd_acc) rd_ptr <= rd_ptr + AW'(1);
      end
      cnt      <= cnt_nxt;
      full_q   <= (cnt_nxt == CW'(DEPTH));
      empty_q  <= (cnt_nxt == '0);
      afull_q  <= (cnt_nxt >= CW'(AFULL_THRESH));
      aempty_q <= (cnt_nxt <= CW'(AEMPTY_THRESH));
    end
  end

  // A fresh error in the same cycle as err_clr leaves the flag set.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ovf_q <= 1'b0;
      udf_q <= 1'b0;
    end else begin
      ovf_q <= (!flush && wr_en && full_q)  || (ovf_q && !err_clr);
      udf_q <= (!flush && rd_en && empty_q) || (udf_q && !err_clr);
    end
  end

  always_ff @(posedge clk) begin
    if (rst_n && !flush && wr_acc) begin
      mem[wr_ptr] <= din;
    end
  end

  if (FIRST_WORD_FALLTHROUGH != 0) begin : g_fwft
    // Head word is visible straight from storage; forced to zero when empty.
    assign dout = empty_q ? '0 : mem[rd_ptr];
  end else begin : g_std
    logic [WIDTH-1:0] dout_q;
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        dout_q <= '0;
      end else if (!flush && rd_acc) begin
        dout_q <= mem[rd_ptr];
      end
    end
    assign dout = dout_q;
  end

  assign full         = full_q;
  assign empty        = empty_q;
  assign almost_full  = afull_q;
  assign almost_empty = aempty_q;
  assign count        = cnt;
  assign overflow     = ovf_q;
  assign underflow    = udf_q;

endmodule
`default_nettype wire

// File: tb/tb_fifo_prog.sv
`default_nettype none
// ============================================================================
// tb_fifo_prog : scoreboard bench driving a standard and an FWFT fifo_prog
//                from the same stimulus.
// Revision     : 1.0
// ============================================================================
module tb_fifo_prog;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       flush = 1'b0;
  logic       wr_en = 1'b0;
  logic       rd_en = 1'b0;
  logic       err_clr = 1'b0;
  logic [7:0] din = 8'h00;

  logic       s_full, s_afull, s_empty, s_aempty, s_ovf, s_udf;
  logic [7:0] s_dout;
  logic [3:0] s_count;
  logic       f_full, f_afull, f_empty, f_aempty, f_ovf, f_udf;
  logic [7:0] f_dout;
  logic [3:0] f_count;

  fifo_prog #(.WIDTH(8), .DEPTH(8), .FIRST_WORD_FALLTHROUGH(0)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .din(din),
    .full(s_full), .almost_full(s_afull), .rd_en(rd_en), .dout(s_dout),
    .empty(s_empty), .almost_empty(s_aempty), .count(s_count),
    .overflow(s_ovf), .underflow(s_udf), .err_clr(err_clr));

  fifo_prog #(.WIDTH(8), .DEPTH(8), .FIRST_WORD_FALLTHROUGH(1)) dut_fw (
    .clk(clk), .rst_n(rst_n), .flush(flush), .wr_en(wr_en), .din(din),
    .full(f_full), .almost_full(f_afull), .rd_en(rd_en), .dout(f_dout),
    .empty(f_empty), .almost_empty(f_aempty), .count(f_count),
    .overflow(f_ovf), .underflow(f_udf), .err_clr(err_clr));

  always #5 clk = ~clk;

  int         checks = 0;
  int         errors = 0;
  logic [7:0] sb[$];
  logic [7:0] popped = 8'h00;
  logic [7:0] last_pop = 8'h00;
  logic       rd_ok = 1'b0;

  // Drives one cycle and updates the scoreboard from the pre-edge model state.
  task automatic tick(input logic we, input logic re, input logic [7:0] d);
    logic w_ok, r_ok;
    wr_en = we; rd_en = re; din = d;
    w_ok = we && (sb.size() < 8);
    r_ok = re && (sb.size() > 0);
    @(posedge clk); #1;
    rd_ok = 1'b0;
    if (!rst_n) begin
      sb.delete(); last_pop = 8'h00;
    end else if (flush) begin
      sb.delete();
    end else begin
      if (r_ok) begin popped = sb.pop_front(); last_pop = popped; rd_ok = 1'b1; end
      if (w_ok) sb.push_back(d);
    end
    wr_en = 1'b0; rd_en = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tick(0, 0, 8'h00); rst_n = 1'b1;
    checks++; if (s_empty !== 1'b1) begin errors++; $display("FAIL reset_empty got %b want 1", s_empty); end
    checks++; if (s_full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", s_full); end
    checks++; if (s_aempty !== 1'b1 || s_afull !== 1'b0) begin errors++; $display("FAIL reset_almost got ae=%b af=%b want 1 0", s_aempty, s_afull); end
    checks++; if (s_count !== 4'd0 || f_count !== 4'd0) begin errors++; $display("FAIL reset_count got %0d/%0d want 0", s_count, f_count); end
    checks++; if (s_ovf !== 1'b0 || s_udf !== 1'b0) begin errors++; $display("FAIL reset_err got %b%b want 00", s_ovf, s_udf); end
    checks++; if (s_dout !== 8'h00) begin errors++; $display("FAIL reset_dout got %h want 00", s_dout); end
  endtask

  task automatic test_fill_drain();
    for (int i = 0; i < 8; i++) begin
      tick(1, 0, 8'((i + 1) * 8'h11));
      if (i == 0) begin
        checks++; if (s_aempty !== 1'b1) begin errors++; $display("FAIL aempty_at1 got %b want 1", s_aempty); end
      end
      if (i == 1) begin
        checks++; if (s_aempty !== 1'b0) begin errors++; $display("FAIL aempty_at2 got %b want 0", s_aempty); end
      end
      if (i == 5) begin
        checks++; if (s_afull !== 1'b0) begin errors++; $display("FAIL afull_at6 got %b want 0", s_afull); end
      end
      if (i == 6) begin
        checks++; if (s_afull !== 1'b1 || s_full !== 1'b0) begin errors++; $display("FAIL afull_at7 got af=%b f=%b want 1 0", s_afull, s_full); end
      end
    end
    checks++; if (s_full !== 1'b1 || s_count !== 4'd8) begin errors++; $display("FAIL full_at8 got f=%b cnt=%0d want 1 8", s_full, s_count); end
    for (int i = 0; i < 8; i++) begin
      checks++; if (f_dout !== sb[0]) begin errors++; $display("FAIL fwft_head got %h want %h", f_dout, sb[0]); end
      tick(0, 1, 8'h00);
      checks++; if (!rd_ok || s_dout !== popped) begin errors++; $display("FAIL std_read got %h want %h", s_dout, popped); end
    end
    checks++; if (s_empty !== 1'b1 || s_count !== 4'd0) begin errors++; $display("FAIL drained got e=%b cnt=%0d want 1 0", s_empty, s_count); end
  endtask

  task automatic test_full_rw();
    for (int i = 0; i < 8; i++) tick(1, 0, 8'(8'hC0 + i));
    tick(1, 1, 8'hEE);
    checks++; if (s_count !== 4'd7 || s_dout !== 8'hC0) begin errors++; $display("FAIL full_rw got cnt=%0d dout=%h want 7 c0", s_count, s_dout); end
    checks++; if (s_ovf !== 1'b1 || f_ovf !== 1'b1) begin errors++; $display("FAIL overflow_set got %b/%b want 1", s_ovf, f_ovf); end
    err_clr = 1'b1; tick(0, 0, 8'h00); err_clr = 1'b0;
    checks++; if (s_ovf !== 1'b0) begin errors++; $display("FAIL overflow_clr got %b want 0", s_ovf); end
    while (sb.size() > 0) begin
      tick(0, 1, 8'h00);
      checks++; if (s_dout !== popped) begin errors++; $display("FAIL full_rw_drain got %h want %h", s_dout, popped); end
    end
    checks++; if (s_empty !== 1'b1) begin errors++; $display("FAIL full_rw_empty got %b want 1", s_empty); end
  endtask

  task automatic test_underflow();
    tick(0, 1, 8'h00);
    checks++; if (s_udf !== 1'b1 || s_count !== 4'd0 || s_dout !== last_pop) begin errors++; $display("FAIL underflow got u=%b cnt=%0d dout=%h want 1 0 %h", s_udf, s_count, s_dout, last_pop); end
    err_clr = 1'b1; tick(0, 1, 8'h00);
    checks++; if (s_udf !== 1'b1) begin errors++; $display("FAIL underflow_win got %b want 1", s_udf); end
    tick(0, 0, 8'h00); err_clr = 1'b0;
    checks++; if (s_udf !== 1'b0) begin errors++; $display("FAIL underflow_clr got %b want 0", s_udf); end
  endtask

  task automatic test_fwft();
    tick(1, 0, 8'hA5);
    checks++; if (f_empty !== 1'b0 || f_dout !== 8'hA5) begin errors++; $display("FAIL fwft_show got e=%b dout=%h want 0 a5", f_empty, f_dout); end
    tick(0, 1, 8'h00);
    checks++; if (f_empty !== 1'b1 || f_count !== 4'd0) begin errors++; $display("FAIL fwft_pop got e=%b cnt=%0d want 1 0", f_empty, f_count); end
    checks++; if (s_dout !== 8'hA5) begin errors++; $display("FAIL std_after_fwft got %h want a5", s_dout); end
  endtask

  task automatic test_flush_wrap();
    tick(0, 1, 8'h00);
    for (int i = 0; i < 5; i++) tick(1, 0, 8'(8'h50 + i));
    checks++; if (s_count !== 4'd5) begin errors++; $display("FAIL pre_flush got %0d want 5", s_count); end
    flush = 1'b1; tick(1, 0, 8'h99); flush = 1'b0;
    checks++; if (s_count !== 4'd0 || s_empty !== 1'b1 || f_empty !== 1'b1) begin errors++; $display("FAIL flush got cnt=%0d e=%b want 0 1", s_count, s_empty); end
    checks++; if (s_udf !== 1'b1 || s_ovf !== 1'b0 || s_dout !== last_pop) begin errors++; $display("FAIL flush_hold got u=%b o=%b dout=%h want 1 0 %h", s_udf, s_ovf, s_dout, last_pop); end
    err_clr = 1'b1; tick(0, 0, 8'h00); err_clr = 1'b0;
    for (int i = 0; i < 4; i++) tick(1, 0, 8'(8'h60 + i));
    for (int i = 0; i < 20; i++) begin
      logic we, re;
      we = ($urandom_range(0, 3) != 0);
      re = ($urandom_range(0, 1) != 0);
      if (re && sb.size() > 0) begin
        checks++; if (f_dout !== sb[0]) begin errors++; $display("FAIL wrap_fwft got %h want %h", f_dout, sb[0]); end
      end
      tick(we, re, 8'(8'h70 + i));
      if (rd_ok) begin
        checks++; if (s_dout !== popped) begin errors++; $display("FAIL wrap_std got %h want %h", s_dout, popped); end
      end
    end
    checks++; if (s_count !== 4'(sb.size())) begin errors++; $display("FAIL wrap_count got %0d want %0d", s_count, sb.size()); end
    while (sb.size() > 0) begin
      tick(0, 1, 8'h00);
      checks++; if (s_dout !== popped) begin errors++; $display("FAIL wrap_drain got %h want %h", s_dout, popped); end
    end
  endtask

  task automatic test_reset_mid();
    for (int i = 0; i < 9; i++) tick(1, 0, 8'(8'h80 + i));
    tick(0, 1, 8'h00);
    tick(0, 1, 8'h00);
    checks++; if (s_count !== 4'd6 || s_ovf !== 1'b1) begin errors++; $display("FAIL pre_reset got cnt=%0d o=%b want 6 1", s_count, s_ovf); end
    rst_n = 1'b0; tick(1, 1, 8'h77); rst_n = 1'b1;
    checks++; if (s_count !== 4'd0 || s_empty !== 1'b1 || s_full !== 1'b0) begin errors++; $display("FAIL mid_reset got cnt=%0d e=%b f=%b want 0 1 0", s_count, s_empty, s_full); end
    checks++; if (s_aempty !== 1'b1 || s_afull !== 1'b0 || s_ovf !== 1'b0 || s_udf !== 1'b0 || s_dout !== 8'h00) begin errors++; $display("FAIL mid_reset_out got ae=%b af=%b o=%b u=%b dout=%h want 1 0 0 0 00", s_aempty, s_afull, s_ovf, s_udf, s_dout); end
    tick(1, 0, 8'h3C);
    tick(0, 1, 8'h00);
    checks++; if (s_dout !== 8'h3C || s_empty !== 1'b1) begin errors++; $display("FAIL post_reset got dout=%h e=%b want 3c 1", s_dout, s_empty); end
  endtask

  initial begin
    test_reset();
    test_fill_drain();
    test_full_rw();
    test_underflow();
    test_fwft();
    test_flush_wrap();
    test_reset_mid();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
